hostsystem_cpu_debug_ocimem_ctrl: RTL
=====================================

// Module: hostsystem_cpu_debug_ocimem_ctrl
// PURPOSE
//  On-chip debug memory controller, directly downstream of the debug-slave sysclk stage.
//  Consumes jdo and the take_*_ocimem_* one-cycle pulses; runs JTAG reads/writes on a local debug RAM.
//  Returns MonDReg, monitor_ready and monitor_error to the debug-slave TCK stage.
//  Also serves the CPU debug master on an Avalon-MM slave port, arbitrated with JTAG.
// PARAMETERS
//  ADDR_W  8  word-address width; RAM depth = 2**ADDR_W words of 32 bits
// PORTS
//  clk                      in   1   system clock; the only clock
//  reset                    in   1   synchronous, active-high reset
//  jdo                      in   38  JTAG data word from the sysclk stage
//  take_action_ocimem_a     in   1   pulse: load address, optionally read
//  take_action_ocimem_b     in   1   pulse: write jdo[34:3] at current address
//  take_no_action_ocimem_a  in   1   pulse: read at current address
//  MonDReg                  out  32  last JTAG read data
//  monitor_ready            out  1   JTAG operation complete
//  monitor_error            out  1   sticky JTAG overrun flag
//  avs_address              in   ADDR_W  CPU word address
//  avs_read / avs_write     in   1   CPU access strobes; mutually exclusive
//  avs_writedata            in   32  CPU write data
//  avs_byteenable           in   4   CPU byte lanes
//  avs_debugaccess          in   1   write permitted only when 1
//  avs_readdata             out  32  CPU read data
//  avs_waitrequest          out  1   CPU stall
// BEHAVIOUR
//  - Reset: MonDReg=0, monitor_ready=0, monitor_error=0, mon_addr=0, pending flags=0, state=IDLE.
//  - Reset also forces avs_readdata=0. RAM contents are not reset.
//  - Reset mid-operation: pending op dropped and no RAM write occurs in the reset cycle.
//  - Pulse a: mon_addr<=jdo[ADDR_W+1:2]. If jdo[34]=1, set rd_pend.
//  - Pulse a with jdo[35]=1 clears monitor_error.
//  - Pulse b: wr_data<=jdo[34:3]; set wr_pend.
//  - Pulse no_action_a: set rd_pend.
//  - Simultaneous pulses: priority a > b > no_action_a. Lower-priority pulses are ignored, no error.
//  - Any pulse that sets a pending flag clears monitor_ready that cycle.
//  - Overrun: pulse arrives while rd_pend or wr_pend is already set.
//    Response: new op dropped, monitor_error<=1. Address load from pulse a still applies.
//  - FSM states: IDLE, J_RD, A_RD.
//  - IDLE, priority 1, wr_pend: RAM[mon_addr]<=wr_data (all bytes); mon_addr++.
//    Clear wr_pend; monitor_ready<=1 next edge; stay IDLE.
//  - IDLE, priority 2, rd_pend: RAM read at mon_addr; -> J_RD.
//  - IDLE, priority 3, avs_read: RAM read at avs_address; -> A_RD.
//  - IDLE, priority 4, avs_write: write per byteenable, only if avs_debugaccess; always completes.
//  - J_RD: MonDReg<=RAM q; mon_addr++; clear rd_pend; monitor_ready<=1; -> IDLE.
//  - A_RD: avs_readdata<=RAM q; -> IDLE.
//  - avs_waitrequest=0 only in: IDLE cycle that performs the avs_write; and A_RD.
//    Otherwise 1 whenever avs_read|avs_write.
//  - Avalon latency: write 1 cycle; read 2 cycles.
//  - JTAG latency: write 1 cycle; read 2 cycles after pulse, plus any in-flight A_RD.
//  - mon_addr wraps 2**ADDR_W-1 -> 0 silently, no error.
//  - RAM: single port, 1-cycle registered read, read-old-data on same address.
// TESTING
//  - Reset: assert reset 2 cycles -> all outputs 0, waitrequest 0 when idle.
//  - JTAG write/read: pulse b with jdo[34:3]=0xDEADBEEF at addr 5.
//    Then pulse a, jdo[9:2]=5, jdo[34]=1 -> MonDReg=0xDEADBEEF 2 cycles later.
//    Expect monitor_ready=1 and mon_addr=6.
//  - Wrap: pulse a, addr 0xFF, read -> next no_action_a reads addr 0x00; monitor_error stays 0.
//  - Overrun: avs_read stalling plus two pulse b back-to-back -> monitor_error=1, one write only.
//    Pulse a with jdo[35]=1 -> monitor_error=0.
//  - Arbitration: avs_read addr 3 asserted in the same cycle as rd_pend.
//    JTAG serviced first; avs_waitrequest=1 for 3 cycles; avs_readdata=RAM[3].
//  - Protection: avs_write 0x12345678, byteenable=4'b0011, debugaccess=1 -> RAM low half updated.
//    Same write with debugaccess=0 -> RAM unchanged, waitrequest=0.

Source files
------------

// File: rtl/hostsystem_cpu_debug_ocimem_ctrl_if.sv
// Avalon-MM bus between the CPU debug master and the OCI debug memory.
//   master : CPU side, drives address/strobes/data and receives readdata/waitrequest.
//   slave  : memory controller side.
// Ports (all in the master -> slave direction unless noted):
//   avs_address[ADDR_W]   word address
//   avs_read, avs_write   access strobes, mutually exclusive
//   avs_writedata[32]     write data
//   avs_byteenable[4]     byte lanes of the write
//   avs_debugaccess       writes only take effect when 1
//   avs_readdata[32]      (slave -> master) read data
//   avs_waitrequest       (slave -> master) stall
interface hostsystem_cpu_debug_ocimem_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] avs_address;
    logic              avs_read;
    logic              avs_write;
    logic [31:0]       avs_writedata;
    logic [3:0]        avs_byteenable;
    logic              avs_debugaccess;
    logic [31:0]       avs_readdata;
    logic              avs_waitrequest;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata,
               avs_byteenable, avs_debugaccess,
        input  avs_readdata, avs_waitrequest
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata,
               avs_byteenable, avs_debugaccess,
        output avs_readdata, avs_waitrequest
    );
endinterface

// File: rtl/hostsystem_cpu_debug_ocimem_ctrl.sv
// On-chip debug memory controller.
// Executes JTAG read/write requests (delivered as one-cycle take_* pulses with
// their payload on jdo) against a local single-port debug RAM, and shares that
// RAM with the CPU debug master through an Avalon-MM slave port.
// Ports:
//   clk, reset                 system clock, synchronous active-high reset
//   jdo[38]                    JTAG payload: [ADDR_W+1:2] address, [34] read
//                              request / bit 31 of write data window [34:3],
//                              [35] clear monitor_error
//   take_action_ocimem_a       load address, optional read
//   take_action_ocimem_b       write jdo[34:3] at the current address
//   take_no_action_ocimem_a    read at the current address
//   MonDReg[32]                last JTAG read data
//   monitor_ready              JTAG operation complete
//   monitor_error              sticky overrun flag
//   avs                        Avalon-MM slave bus (see interface file)
module hostsystem_cpu_debug_ocimem_ctrl #(
    parameter int ADDR_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [37:0] jdo,
    input  logic        take_action_ocimem_a,
    input  logic        take_action_ocimem_b,
    input  logic        take_no_action_ocimem_a,
    output logic [31:0] MonDReg,
    output logic        monitor_ready,
    output logic        monitor_error,
    hostsystem_cpu_debug_ocimem_ctrl_if.slave avs
);

    typedef enum logic [1:0] {ST_IDLE, ST_J_RD, ST_A_RD} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] mon_addr_q, mon_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic              rd_pend_q, rd_pend_d;
    logic              wr_pend_q, wr_pend_d;
    logic              monitor_ready_q, monitor_ready_d;
    logic              monitor_error_q, monitor_error_d;
    logic [31:0]       mon_dreg_q, mon_dreg_d;
    logic [31:0]       avs_readdata_q, avs_readdata_d;

    // Debug RAM (not reset) and its single port controls.
    logic [31:0]       mem [0:(2**ADDR_W)-1];
    logic [31:0]       ram_rd_q;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [31:0]       ram_wdata;
    logic [3:0]        ram_be;

    logic jtag_busy;
    logic unused_jdo_bits;

    assign jtag_busy       = rd_pend_q | wr_pend_q;
    assign unused_jdo_bits = ^{jdo[37:36], jdo[1:0]};

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            mon_addr_q      <= '0;
            wr_data_q       <= '0;
            rd_pend_q       <= 1'b0;
            wr_pend_q       <= 1'b0;
            monitor_ready_q <= 1'b0;
            monitor_error_q <= 1'b0;
            mon_dreg_q      <= '0;
            avs_readdata_q  <= '0;
        end else begin
            state_q         <= state_d;
            mon_addr_q      <= mon_addr_d;
            wr_data_q       <= wr_data_d;
            rd_pend_q       <= rd_pend_d;
            wr_pend_q       <= wr_pend_d;
            monitor_ready_q <= monitor_ready_d;
            monitor_error_q <= monitor_error_d;
            mon_dreg_q      <= mon_dreg_d;
            avs_readdata_q  <= avs_readdata_d;
        end
    end

    // RAM: byte-lane writes, registered read returning the old word on a
    // same-address write.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (ram_we && ram_be[i]) begin
                mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
            end
        end
        ram_rd_q <= mem[ram_addr];
    end

    // Next-state logic: a pending JTAG write is handled in place in IDLE, so
    // it blocks both reads from starting that cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!wr_pend_q) begin
                    if (rd_pend_q) begin
                        state_d = ST_J_RD;
                    end else if (avs.avs_read) begin
                        state_d = ST_A_RD;
                    end
                end
            end
            ST_J_RD: state_d = ST_IDLE;
            ST_A_RD: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic: RAM port steering and Avalon stall.
    always_comb begin
        ram_addr            = mon_addr_q;
        ram_we              = 1'b0;
        ram_wdata           = wr_data_q;
        ram_be              = 4'hF;
        avs.avs_waitrequest = avs.avs_read | avs.avs_write;
        case (state_q)
            ST_IDLE: begin
                if (wr_pend_q) begin
                    ram_we = 1'b1;
                end else if (rd_pend_q) begin
                    ram_we = 1'b0;
                end else if (avs.avs_read) begin
                    ram_addr = avs.avs_address;
                end else if (avs.avs_write) begin
                    // Unprivileged writes are accepted but discarded.
                    ram_addr            = avs.avs_address;
                    ram_wdata           = avs.avs_writedata;
                    ram_be              = avs.avs_byteenable;
                    ram_we              = avs.avs_debugaccess;
                    avs.avs_waitrequest = 1'b0;
                end
            end
            ST_A_RD: avs.avs_waitrequest = 1'b0;
            default: ;
        endcase
        // No RAM write may land in a reset cycle.
        if (reset) begin
            ram_we = 1'b0;
        end
    end

    // Datapath: FSM completions first, then JTAG pulses, which override the
    // address increment when pulse a reloads the address in the same cycle.
    always_comb begin
        mon_addr_d      = mon_addr_q;
        wr_data_d       = wr_data_q;
        rd_pend_d       = rd_pend_q;
        wr_pend_d       = wr_pend_q;
        monitor_ready_d = monitor_ready_q;
        monitor_error_d = monitor_error_q;
        mon_dreg_d      = mon_dreg_q;
        avs_readdata_d  = avs_readdata_q;

        case (state_q)
            ST_IDLE: begin
                if (wr_pend_q) begin
                    mon_addr_d      = mon_addr_q + 1'b1;
                    wr_pend_d       = 1'b0;
                    monitor_ready_d = 1'b1;
                end
            end
            ST_J_RD: begin
                mon_dreg_d      = ram_rd_q;
                mon_addr_d      = mon_addr_q + 1'b1;
                rd_pend_d       = 1'b0;
                monitor_ready_d = 1'b1;
            end
            ST_A_RD: avs_readdata_d = ram_rd_q;
            default: ;
        endcase

        // Only pulses carrying an operation can overrun; an overrun drops
        // the new op (including its write data) and flags the error.
        if (take_action_ocimem_a) begin
            mon_addr_d = jdo[ADDR_W+1:2];
            if (jdo[35]) begin
                monitor_error_d = 1'b0;
            end
            if (jdo[34]) begin
                if (jtag_busy) begin
                    monitor_error_d = 1'b1;
                end else begin
                    rd_pend_d       = 1'b1;
                    monitor_ready_d = 1'b0;
                end
            end
        end else if (take_action_ocimem_b) begin
            if (jtag_busy) begin
                monitor_error_d = 1'b1;
            end else begin
                wr_data_d       = jdo[34:3];
                wr_pend_d       = 1'b1;
                monitor_ready_d = 1'b0;
            end
        end else if (take_no_action_ocimem_a) begin
            if (jtag_busy) begin
                monitor_error_d = 1'b1;
            end else begin
                rd_pend_d       = 1'b1;
                monitor_ready_d = 1'b0;
            end
        end
    end

    assign MonDReg       = mon_dreg_q;
    assign monitor_ready = monitor_ready_q;
    assign monitor_error = monitor_error_q;
    // Read data is presented straight from the RAM in A_RD, the cycle the
    // stall drops, and held afterwards.
    assign avs.avs_readdata = (state_q == ST_A_RD) ? ram_rd_q : avs_readdata_q;

endmodule
